// File: rtl/inject_ctrl_if.sv
// ---------------------------------------------------------------------------
// inject_ctrl_if
//   Bundles the node-side push handshake and the router injection port of
//   inject_ctrl.
//   Node side   : node_valid, node_data, node_srcdst -> controller; node_ready <-
//   Router side : inj_data, inj_srcdst, inj_active -> router; inj_accepted <-
//   Modports:
//     slave  - used by inject_ctrl (consumes node flits, drives injection port)
//     master - used by the environment (node + router) around the controller
// ---------------------------------------------------------------------------
interface inject_ctrl_if #(
  parameter int LINKWIDTH = 32,
  parameter int ADDRBITS2 = 8
);
  logic                 node_valid;
  logic [LINKWIDTH-1:0] node_data;
  logic [ADDRBITS2-1:0] node_srcdst;
  logic                 node_ready;
  logic [LINKWIDTH-1:0] inj_data;
  logic [ADDRBITS2-1:0] inj_srcdst;
  logic                 inj_active;
  logic                 inj_accepted;

  modport slave (
    input  node_valid, node_data, node_srcdst, inj_accepted,
    output node_ready, inj_data, inj_srcdst, inj_active
  );

  modport master (
    output node_valid, node_data, node_srcdst, inj_accepted,
    input  node_ready, inj_data, inj_srcdst, inj_active
  );
endinterface

// File: rtl/inject_ctrl.sv
// ---------------------------------------------------------------------------
// inject_ctrl
//   Node-side injection controller for a bufferless router. Flits offered by
//   the local node are buffered in a DEPTH-entry FIFO; the head flit is held
//   on the router injection port until the router accepts it.
//
//   Ports:
//     clock        - single clock, rising edge
//     rst_n        - asynchronous active-low reset
//     throttle     - (only with INJ_THROTTLE_EN) suppress new presentations
//     bus          - inject_ctrl_if.slave: node push handshake + injection port
//     starved      - head refused for STARVE_LIMIT consecutive cycles
//     occupancy    - registered FIFO count
//     inj_total    - accepted-flit counter, wraps modulo 2^16
//
//   Optional feature macro: INJ_THROTTLE_EN (adds the throttle input).
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | nothing on the injection port; outputs forced to zero
//   PRESENT | FIFO head driven on the injection port, held until accepted
// ---------------------------------------------------------------------------
module inject_ctrl #(
  parameter int LINKWIDTH    = 32,
  parameter int ADDRBITS2    = 8,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                      clock,
  input  logic                      rst_n,
`ifdef INJ_THROTTLE_EN
  input  logic                      throttle,
`endif
  inject_ctrl_if.slave              bus,
  output logic                      starved,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [15:0]               inj_total
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = LINKWIDTH + ADDRBITS2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    LIMIT_C = 8'(STARVE_LIMIT);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      starve_q, starve_d;
  logic [15:0]     total_q;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;
  logic            node_ready_i;
  logic            present;
  logic            push;
  logic            pop;
  logic            thr;

`ifdef INJ_THROTTLE_EN
  assign thr = throttle;
`else
  assign thr = 1'b0;
`endif

  // Ready comes from the registered count only, so a full FIFO refuses a
  // push even in the cycle a pop frees an entry.
  assign node_ready_i = (count_q < DEPTH_C);
  assign present      = (state_q == PRESENT);
  assign push         = bus.node_valid && node_ready_i;
  assign pop          = present && bus.inj_accepted;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A presented flit is never withdrawn; throttle only blocks starting a
  // new presentation (from IDLE or right after an accept).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if ((count_q != '0) && !thr) state_d = PRESENT;
      end
      PRESENT: begin
        if (pop) state_d = ((count_d != '0) && !thr) ? PRESENT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = '0;
    if (present && !bus.inj_accepted)
      starve_d = (starve_q == LIMIT_C) ? starve_q : starve_q + 8'd1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      total_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        total_q  <= total_q + 16'd1;
      end
    end
  end

  // Storage needs no reset: pointers and count define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= {bus.node_data, bus.node_srcdst};
  end

  assign head = mem[rd_ptr_q];

  assign bus.node_ready = node_ready_i;
  assign bus.inj_active = present;
  assign bus.inj_data   = present ? head[EW-1:ADDRBITS2] : '0;
  assign bus.inj_srcdst = present ? head[ADDRBITS2-1:0]  : '0;

  assign starved   = (starve_q == LIMIT_C);
  assign occupancy = count_q;
  assign inj_total = total_q;

endmodule
